// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge
//   Z80 I/O-port bridge between the MSX bus pins and the VDP CPU port.
//   A masked address decoder generates chip select. The rd/wr strobes are
//   synchronised and de-glitched, and each bus cycle becomes exactly one
//   queued request. Queued requests are replayed in order to the VDP under
//   a req/ack handshake.
// Ports
//   clk_w, reset_n_w          clock, asynchronous active-low reset
//   cpu_addr/iorq_n/rd_n/wr_n raw CPU bus pins
//   cpu_din                   raw CPU write data
//   cs_n, cpu_doe, cpu_dout   combinational decode, data-bus enable and read data
//   vdp_req/wrt/adr/dbo       head-of-queue request to the VDP
//   vdp_ack                   one-cycle accept pulse from the VDP
//   vdp_dbi                   VDP read data
//   fifo_level, overflow      queue occupancy and sticky drop flag
module cpu_io_bridge #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h98,
  parameter logic [ADDR_W-1:0] ADDR_MASK   = 8'hFC,
  parameter int                PORT_BITS   = 2,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILTER_LEN  = 3,
  parameter int                FIFO_DEPTH  = 4,
  localparam int               LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_w,
  input  logic                 reset_n_w,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic                 cpu_iorq_n,
  input  logic                 cpu_rd_n,
  input  logic                 cpu_wr_n,
  input  logic [7:0]           cpu_din,
  output logic                 cs_n,
  output logic                 cpu_doe,
  output logic [7:0]           cpu_dout,
  output logic                 vdp_req,
  output logic                 vdp_wrt,
  output logic [PORT_BITS-1:0] vdp_adr,
  output logic [7:0]           vdp_dbo,
  input  logic                 vdp_ack,
  input  logic [7:0]           vdp_dbi,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FILTER_LEN) + 1;
  localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  typedef struct packed {
    logic                 wrt;
    logic [PORT_BITS-1:0] adr;
    logic [7:0]           data;
  } entry_t;

  // ---------------- Decode (no clock) ----------------
  logic       match;
  logic [1:0] strobe_n;  // [1] = csr_n, [0] = csw_n

  assign match    = ((cpu_addr ^ BASE_ADDR) & ADDR_MASK) == '0;
  assign cs_n     = ~(match & ~cpu_iorq_n);
  assign cpu_doe  = ~cs_n & ~cpu_rd_n;
  assign cpu_dout = vdp_dbi;
  assign strobe_n = {~(~cs_n & ~cpu_rd_n), ~(~cs_n & ~cpu_wr_n)};

  // ---------------- Synchroniser ----------------
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] sync_d [SYNC_STAGES];
  logic [1:0] sync_out;

  always_comb begin
    sync_d[0] = strobe_n;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------- Glitch filter ----------------
  // A channel flips only after FILTER_LEN consecutive samples disagree with it.
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] fcnt_q [2];
  logic [CNT_W-1:0] fcnt_d [2];

  // NOTE: every always_comb output gets a default on entry so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync_out[i] != filt_q[i]) begin
        if (fcnt_q[i] == CNT_W'(FILTER_LEN - 1)) filt_d[i] = sync_out[i];
        else                                     fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      filt_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      filt_q    <= filt_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
    end
  end

  // ---------------- Arming after reset ----------------
  // The synchroniser resets to "idle", so a strobe already held at release
  // would look like a fresh edge. Detection is enabled only once the
  // pipeline holds real pin samples and both strobes are seen inactive.
  logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
  logic               primed, armed_q, armed_d;

  assign primed = (prime_cnt_q == PRIME_W'(SYNC_STAGES));

  always_comb begin
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PRIME_W'(1);
    armed_d     = armed_q | (primed & (sync_out == 2'b11) & (filt_q == 2'b11));
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      prime_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      armed_q     <= armed_d;
    end
  end

  // ---------------- Detector FSM ----------------
  state_t state_q, state_d;
  logic   push;
  entry_t push_entry;

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && (filt_q == 2'b10 || filt_q == 2'b01)) state_d = ACTIVE;
      ACTIVE:  if (filt_q == 2'b11) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (state_q == IDLE && armed_q) begin
      case (filt_q)
        2'b10: begin
          push       = 1'b1;
          push_entry = '{wrt: 1'b1, adr: cpu_addr[PORT_BITS-1:0], data: cpu_din};
        end
        2'b01: begin
          push       = 1'b1;
          push_entry = '{wrt: 1'b0, adr: cpu_addr[PORT_BITS-1:0], data: 8'h00};
        end
        default: ;
      endcase
    end
  end

  // ---------------- Request FIFO ----------------
  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             empty, full, pop, do_push;
  entry_t           head;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop     = vdp_ack & ~empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !do_push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: queue storage has no reset; stale contents are never visible
  // because the head outputs are forced to zero while the queue is empty.
  always_ff @(posedge clk_w) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign vdp_req    = ~empty;
  assign vdp_wrt    = ~empty & head.wrt;
  assign vdp_adr    = {PORT_BITS{~empty}} & head.adr;
  assign vdp_dbo    = {8{~empty}} & head.data;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb_cpu_io_bridge
//   Directed bench for cpu_io_bridge with default parameters. A table of
//   decode vectors is applied while reset is held (the decode path stays
//   live), followed by hand-written sequences for the clocked behaviour.
module tb_cpu_io_bridge;

  logic       clk_w = 1'b0;
  logic       reset_n_w = 1'b0;
  logic [7:0] cpu_addr;
  logic       cpu_iorq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0] cpu_din;
  logic       cs_n, cpu_doe;
  logic [7:0] cpu_dout;
  logic       vdp_req, vdp_wrt;
  logic [1:0] vdp_adr;
  logic [7:0] vdp_dbo;
  logic       vdp_ack;
  logic [7:0] vdp_dbi;
  logic [2:0] fifo_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  cpu_io_bridge dut (
    .clk_w      (clk_w),
    .reset_n_w  (reset_n_w),
    .cpu_addr   (cpu_addr),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_din    (cpu_din),
    .cs_n       (cs_n),
    .cpu_doe    (cpu_doe),
    .cpu_dout   (cpu_dout),
    .vdp_req    (vdp_req),
    .vdp_wrt    (vdp_wrt),
    .vdp_adr    (vdp_adr),
    .vdp_dbo    (vdp_dbo),
    .vdp_ack    (vdp_ack),
    .vdp_dbi    (vdp_dbi),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk_w = ~clk_w;

  typedef struct {
    logic [7:0] addr;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] dbi;
    logic       exp_cs_n;
    logic       exp_doe;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_w);
    #1;
  endtask

  task automatic bus_idle();
    cpu_iorq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  // One bus cycle of len clocks, then enough idle time for the strobe to
  // clear the synchroniser and filter.
  task automatic strobe(input logic [7:0] a, input logic [7:0] d, input logic is_wr, input int len);
    cpu_addr   = a;
    cpu_din    = d;
    cpu_iorq_n = 1'b0;
    if (is_wr) cpu_wr_n = 1'b0;
    else       cpu_rd_n = 1'b0;
    cyc(len);
    bus_idle();
    cyc(8);
  endtask

  task automatic pulse_ack();
    vdp_ack = 1'b1;
    cyc(1);
    vdp_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_n_w = 1'b0;
    cyc(2);
    reset_n_w = 1'b1;
    cyc(6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h98, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[1] = '{8'h9B, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0};
    vecs[2] = '{8'h9C, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0};
    vecs[3] = '{8'h99, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0};
    vecs[4] = '{8'h97, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[5] = '{8'h18, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0};
    vecs[6] = '{8'h9A, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1};
    vecs[7] = '{8'h9B, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};

    cpu_addr = 8'h00;
    cpu_din  = 8'h00;
    vdp_ack  = 1'b0;
    vdp_dbi  = 8'h00;
    bus_idle();
    reset_n_w = 1'b0;
    #3;

    // Decode table, applied with reset held low.
    for (int i = 0; i < 8; i++) begin
      cpu_addr   = vecs[i].addr;
      cpu_iorq_n = vecs[i].iorq_n;
      cpu_rd_n   = vecs[i].rd_n;
      cpu_wr_n   = vecs[i].wr_n;
      vdp_dbi    = vecs[i].dbi;
      #2;
      check($sformatf("vec%0d cs_n", i), 32'(cs_n), 32'(vecs[i].exp_cs_n));
      check($sformatf("vec%0d cpu_doe", i), 32'(cpu_doe), 32'(vecs[i].exp_doe));
      check($sformatf("vec%0d cpu_dout", i), 32'(cpu_dout), 32'(vecs[i].dbi));
    end
    bus_idle();

    check("rst vdp_req", 32'(vdp_req), 32'd0);
    check("rst vdp_wrt", 32'(vdp_wrt), 32'd0);
    check("rst vdp_adr", 32'(vdp_adr), 32'd0);
    check("rst vdp_dbo", 32'(vdp_dbo), 32'd0);
    check("rst fifo_level", 32'(fifo_level), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);

    @(posedge clk_w);
    #1;
    reset_n_w = 1'b1;
    cyc(6);

    // 1. Write 0x5A to port 0x99: filtered edge after 5 clks, req one clk later.
    cpu_addr   = 8'h99;
    cpu_din    = 8'h5A;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    cyc(5);
    check("t1 req before push", 32'(vdp_req), 32'd0);
    cyc(1);
    check("t1 req", 32'(vdp_req), 32'd1);
    check("t1 wrt", 32'(vdp_wrt), 32'd1);
    check("t1 adr", 32'(vdp_adr), 32'd1);
    check("t1 dbo", 32'(vdp_dbo), 32'h5A);
    check("t1 level", 32'(fifo_level), 32'd1);
    pulse_ack();
    check("t1 level after ack", 32'(fifo_level), 32'd0);
    check("t1 req after ack", 32'(vdp_req), 32'd0);
    cyc(3);
    bus_idle();
    cyc(8);
    check("t1 single push", 32'(fifo_level), 32'd0);

    // 2. Two-clock glitch is filtered out; port 0x9C is not decoded.
    cpu_addr   = 8'h99;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    cyc(2);
    bus_idle();
    cyc(10);
    check("t2 glitch level", 32'(fifo_level), 32'd0);
    check("t2 glitch req", 32'(vdp_req), 32'd0);
    cpu_addr   = 8'h9C;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    #1;
    check("t2 9C cs_n", 32'(cs_n), 32'd1);
    cyc(10);
    bus_idle();
    cyc(8);
    check("t2 9C level", 32'(fifo_level), 32'd0);

    // 3. Five writes into a depth-4 queue with no acks.
    do_reset();
    for (int i = 1; i <= 5; i++) strobe(8'h99, 8'(i), 1'b1, 10);
    check("t3 level full", 32'(fifo_level), 32'd4);
    check("t3 overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3 req%0d", i), 32'(vdp_req), 32'd1);
      check($sformatf("t3 dbo%0d", i), 32'(vdp_dbo), 32'(i + 1));
      pulse_ack();
    end
    check("t3 level drained", 32'(fifo_level), 32'd0);
    check("t3 req drained", 32'(vdp_req), 32'd0);
    check("t3 overflow sticky", 32'(overflow), 32'd1);

    // 4. Full queue, push and ack in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) strobe(8'h98, 8'h11 + 8'(i), 1'b1, 10);
    check("t4 level full", 32'(fifo_level), 32'd4);
    check("t4 overflow clear", 32'(overflow), 32'd0);
    cpu_addr   = 8'h98;
    cpu_din    = 8'h15;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    cyc(5);
    vdp_ack = 1'b1;
    cyc(1);
    vdp_ack = 1'b0;
    check("t4 level kept", 32'(fifo_level), 32'd4);
    check("t4 overflow kept", 32'(overflow), 32'd0);
    check("t4 head advanced", 32'(vdp_dbo), 32'h12);
    cyc(3);
    bus_idle();
    cyc(8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4 dbo%0d", i), 32'(vdp_dbo), 32'h12 + 32'(i));
      pulse_ack();
    end
    check("t4 level drained", 32'(fifo_level), 32'd0);

    // 5. Write then read to port 1; the read waits behind the write.
    strobe(8'h99, 8'h77, 1'b1, 10);
    cpu_addr   = 8'h99;
    cpu_iorq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    vdp_dbi    = 8'hC3;
    #1;
    check("t5 doe", 32'(cpu_doe), 32'd1);
    check("t5 dout", 32'(cpu_dout), 32'hC3);
    cyc(10);
    bus_idle();
    cyc(8);
    check("t5 level", 32'(fifo_level), 32'd2);
    cyc(3);
    check("t5 head wrt", 32'(vdp_wrt), 32'd1);
    check("t5 head dbo", 32'(vdp_dbo), 32'h77);
    pulse_ack();
    check("t5 read req", 32'(vdp_req), 32'd1);
    check("t5 read wrt", 32'(vdp_wrt), 32'd0);
    check("t5 read adr", 32'(vdp_adr), 32'd1);
    check("t5 read dbo", 32'(vdp_dbo), 32'h00);
    pulse_ack();
    check("t5 level drained", 32'(fifo_level), 32'd0);

    // 6. Reset while a request is pending and wr_n is held low.
    cpu_addr   = 8'h99;
    cpu_din    = 8'h44;
    cpu_iorq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    cyc(6);
    check("t6 req pending", 32'(vdp_req), 32'd1);
    #2;
    reset_n_w = 1'b0;
    #1;
    check("t6 rst req", 32'(vdp_req), 32'd0);
    check("t6 rst wrt", 32'(vdp_wrt), 32'd0);
    check("t6 rst dbo", 32'(vdp_dbo), 32'd0);
    check("t6 rst adr", 32'(vdp_adr), 32'd0);
    check("t6 rst level", 32'(fifo_level), 32'd0);
    check("t6 cs_n live", 32'(cs_n), 32'd0);
    cyc(3);
    reset_n_w = 1'b1;
    cyc(20);
    check("t6 held strobe ignored", 32'(fifo_level), 32'd0);
    check("t6 held req", 32'(vdp_req), 32'd0);
    bus_idle();
    cyc(10);
    check("t6 after release", 32'(fifo_level), 32'd0);
    strobe(8'h99, 8'h66, 1'b1, 10);
    check("t6 new level", 32'(fifo_level), 32'd1);
    check("t6 new dbo", 32'(vdp_dbo), 32'h66);
    pulse_ack();
    check("t6 drained", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
